dmem_ctrl: RTL and testbench

Parametrised data memory with a request/done handshake for the MEM stage of the pipelined MIPS core. It supports byte, halfword and word loads/stores with byte lanes, and sign or zero extension on loads. A programmable wait-state count stalls the pipeline through `busy`. Misaligned-access trapping is optional.

---
 rtl/dmem_if.sv | 29 ++
 rtl/dmem_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// dmem_if: request/done bus between the MEM stage and the data memory.
// The MEM stage (master) drives req with the access fields. The memory (slave)
// takes the request on a rising edge where req is high and busy is low. Busy
// stays high while the access is in flight, and done pulses for one cycle
// when it completes. dataOut and err are meaningful in the done cycle.
interface dmem_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req;
  logic                  wen;
  logic [1:0]            size;
  logic                  uns;
  logic [ADDR_WIDTH-1:0] address;
  logic [31:0]           dataIn;
  logic [31:0]           dataOut;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output req, wen, size, uns, address, dataIn,
    input  dataOut, busy, done, err
  );

  modport slave (
    input  req, wen, size, uns, address, dataIn,
    output dataOut, busy, done, err
  );
endinterface

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data memory for the MEM stage.
// - Supports byte, half and word accesses with little-endian lanes.
// - Loads are sign- or zero-extended.
// - LATENCY sets the number of programmable wait states; busy is held while
//   the access is in flight.
// - Optional misaligned-access trap, enabled with `define DMEM_MISALIGN_TRAP_EN.
//   With the trap disabled, the offending low address bits are forced to zero
//   and the access proceeds as an aligned one.
module dmem_ctrl #(
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 32,
  parameter int LATENCY    = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  dmem_if.slave      bus,
  output logic [1:0] dbg_state_o
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  wen_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdat_q;
  logic [31:0]           dout_q, dout_d;

  logic                  accept;
  logic                  access_fire;
  logic                  suppress;
  logic [IDX_W-1:0]      idx;
  logic [1:0]            eff_lo;
  logic [31:0]           rd_word;
  logic [3:0]            be;
  logic [31:0]           wdata;
  logic                  unused_addr_bits;

  logic [31:0] mem [DEPTH];

  // Only the word index and the lane bits are decoded; higher bits wrap.
  assign unused_addr_bits = ^addr_q;
  assign idx = addr_q[IDX_W+1:2];

  // Next-state and request acceptance: a new access can start from IDLE or from DONE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    accept      = 1'b0;
    access_fire = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          accept  = 1'b1;
          cnt_d   = 4'(LATENCY);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          access_fire = rst_n;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.req) begin
          accept  = 1'b1;
          cnt_d   = 4'(LATENCY);
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Effective lane bits: the misaligned low bits of half and word accesses are forced to zero.
  always_comb begin
    eff_lo = 2'b00;
    case (size_q)
      2'b00:   eff_lo = addr_q[1:0];
      2'b01:   eff_lo = {addr_q[1], 1'b0};
      default: eff_lo = 2'b00;
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic misaligned;
  logic err_q;

  assign misaligned = ((size_q == 2'b01) && addr_q[0]) ||
                      (size_q[1] && (addr_q[1:0] != 2'b00));
  assign suppress   = misaligned;

  // The trap flag is captured at the access edge and shown only in DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (access_fire) begin
      err_q <= misaligned;
    end
  end

  assign bus.err = (state_q == S_DONE) && err_q;
`else
  assign suppress = 1'b0;
  assign bus.err  = 1'b0;
`endif

  // Store lane enables and data replicated onto every lane.
  always_comb begin
    be    = 4'b1111;
    wdata = wdat_q;
    case (size_q)
      2'b00: begin
        be    = 4'b0001 << eff_lo;
        wdata = {4{wdat_q[7:0]}};
      end
      2'b01: begin
        be    = eff_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{wdat_q[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = wdat_q;
      end
    endcase
  end

  assign rd_word = mem[idx];

  // Load data path: select the lane, then extend it according to uns.
  always_comb begin
    dout_d = rd_word;
    case (size_q)
      2'b00: begin
        case (eff_lo)
          2'b00:   dout_d = {24'd0, rd_word[7:0]};
          2'b01:   dout_d = {24'd0, rd_word[15:8]};
          2'b10:   dout_d = {24'd0, rd_word[23:16]};
          default: dout_d = {24'd0, rd_word[31:24]};
        endcase
        if (!uns_q && dout_d[7]) dout_d[31:8] = 24'hFF_FFFF;
      end
      2'b01: begin
        dout_d = eff_lo[1] ? {16'd0, rd_word[31:16]} : {16'd0, rd_word[15:0]};
        if (!uns_q && dout_d[15]) dout_d[31:16] = 16'hFFFF;
      end
      default: dout_d = rd_word;
    endcase
  end

  // Control state, latched request fields and the load result register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      wen_q   <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdat_q  <= 32'd0;
      dout_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wen_q  <= bus.wen;
        size_q <= bus.size;
        uns_q  <= bus.uns;
        addr_q <= bus.address;
        wdat_q <= bus.dataIn;
      end
      if (access_fire && !wen_q && !suppress) begin
        dout_q <= dout_d;
      end
    end
  end

  // Memory array: contents are not reset; byte lanes are written on the final WAIT edge.
  always_ff @(posedge clk) begin
    if (access_fire && wen_q && !suppress) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign bus.busy    = (state_q == S_WAIT);
  assign bus.done    = (state_q == S_DONE);
  assign bus.dataOut = dout_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed test of dmem_ctrl with LATENCY=2 and DEPTH=256.
// - A word-array model derives load results from the lane and extension rules.
// - The expected timeline is accept, then LATENCY+1 busy cycles, then one
//   done cycle.
// - A compare process checks busy, done, err and dataOut on every negedge.
// - Literal checks pin the key values independently of the model.
module tb_dmem_ctrl;
  localparam int DEPTH = 256;
  localparam int AW    = 32;
  localparam int LAT   = 2;

  // Clock and reset.
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_if #(.ADDR_WIDTH(AW)) bus ();
  logic [1:0] dbg_state;

  dmem_ctrl #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // Scoreboard state.
  int          total = 0;
  int          bad   = 0;
  bit          check_en = 1'b0;
  logic        exp_busy = 1'b0;
  logic        exp_done = 1'b0;
  logic        exp_err  = 1'b0;
  logic [31:0] exp_dout = 32'd0;
  logic [31:0] mm [DEPTH];
  int          busy_seen = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Per-cycle compare against the timeline model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("busy",    32'(bus.busy), 32'(exp_busy));
      chk("done",    32'(bus.done), 32'(exp_done));
      chk("err",     32'(bus.err),  32'(exp_err));
      chk("dataOut", bus.dataOut,   exp_dout);
    end
  end

  always @(negedge clk) begin
    if (bus.busy === 1'b1) busy_seen++;
  end

  // Model of one access: its effect on the word array and its load result.
  task automatic model_op(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic e, output logic [31:0] r);
    int   idx;
    int   lo;
    logic mis;
    mis = ((sz == 2'b01) && (a % 2 != 0)) || ((sz >= 2'b10) && (a % 4 != 0));
    e = 1'b0;
    r = 32'd0;
`ifdef DMEM_MISALIGN_TRAP_EN
    if (mis) begin
      e = 1'b1;
      return;
    end
`else
    if (mis) e = 1'b0;
`endif
    lo = int'(a % 4);
    if (sz == 2'b01) lo = lo & 2;
    if (sz >= 2'b10) lo = 0;
    idx = int'((a / 4) % DEPTH);
    if (w) begin
      case (sz)
        2'b00:   mm[idx][8*lo +: 8]  = d[7:0];
        2'b01:   mm[idx][8*lo +: 16] = d[15:0];
        default: mm[idx] = d;
      endcase
    end else begin
      case (sz)
        2'b00: begin
          r = (mm[idx] >> (8*lo)) & 32'hFF;
          if (!u && r[7]) r = r | 32'hFFFF_FF00;
        end
        2'b01: begin
          r = (mm[idx] >> (8*lo)) & 32'hFFFF;
          if (!u && r[15]) r = r | 32'hFFFF_0000;
        end
        default: r = mm[idx];
      endcase
    end
  endtask

  // Driver tasks: inputs change 1 time unit after posedge or on negedge.
  task automatic idle();
    bus.req = 1'b0;
    @(posedge clk); #1;
    exp_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
  endtask

  task automatic access(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d);
    logic        e;
    logic [31:0] r;
    bus.req = 1'b1; bus.wen = w; bus.size = sz; bus.uns = u;
    bus.address = a; bus.dataIn = d;
    @(posedge clk); #1;
    model_op(w, sz, u, a, d, e, r);
    exp_busy = 1'b1; exp_done = 1'b0; exp_err = 1'b0;
    // Inputs are junk while busy; the latched request must be unaffected.
    bus.req = 1'($urandom_range(0, 1)); bus.wen = 1'($urandom_range(0, 1));
    bus.size = 2'($urandom_range(0, 3)); bus.address = $urandom; bus.dataIn = $urandom;
    repeat (LAT) begin
      @(posedge clk); #1;
    end
    bus.req = 1'b0;
    @(posedge clk); #1;
    exp_busy = 1'b0; exp_done = 1'b1; exp_err = e;
    if (!w && !e) exp_dout = r;
  endtask

  task automatic lit(input string name, input logic [31:0] exp);
    @(negedge clk);
    chk(name, bus.dataOut, exp);
  endtask

  // Store whose access is aborted by reset during the second WAIT cycle.
  task automatic abort_store(input logic [31:0] a, input logic [31:0] d);
    bus.req = 1'b1; bus.wen = 1'b1; bus.size = 2'b10; bus.uns = 1'b0;
    bus.address = a; bus.dataIn = d;
    @(posedge clk); #1;
    bus.req = 1'b0;
    exp_busy = 1'b1; exp_done = 1'b0; exp_err = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    exp_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0; exp_dout = 32'd0;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bs0;
    // Reset with a request held high: the request must be dropped.
    bus.req = 1'b1; bus.wen = 1'b1; bus.size = 2'b10; bus.uns = 1'b0;
    bus.address = 32'h10; bus.dataIn = 32'h1111_1111;
    @(posedge clk); #1;
    check_en = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.req = 1'b0;
    idle();
    idle();
    chk("reset_state", 32'(dbg_state), 32'd0);

    // Word store then back-to-back word load.
    bs0 = busy_seen;
    access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
    chk("busy_cycles", 32'(busy_seen - bs0), 32'd3);
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    lit("word_load", 32'hDEAD_BEEF);

    // Byte store into a zero word, with signed and unsigned loads.
    access(1'b1, 2'b10, 1'b0, 32'h10, 32'h0000_0000);
    access(1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_0080);
    access(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    lit("byte_signed", 32'hFFFF_FF80);
    access(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    lit("byte_unsigned", 32'h0000_0080);
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    lit("byte_word_view", 32'h8000_0000);
    idle();

    // Half store into the upper lane of a patterned word.
    access(1'b1, 2'b10, 1'b0, 32'h20, 32'hAAAA_AAAA);
    access(1'b1, 2'b01, 1'b0, 32'h22, 32'hFFFF_1234);
    access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    lit("half_store", 32'h1234_AAAA);
    access(1'b0, 2'b01, 1'b0, 32'h20, 32'h0);
    lit("half_signed", 32'hFFFF_AAAA);
    access(1'b0, 2'b01, 1'b1, 32'h20, 32'h0);
    lit("half_unsigned", 32'h0000_AAAA);
    access(1'b1, 2'b00, 1'b0, 32'h21, 32'h0000_005A);
    access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    lit("byte_lane1", 32'h1234_5AAA);

    // Address wrap: 0x400 aliases word 0.
    access(1'b1, 2'b10, 1'b0, 32'h000, 32'h1122_3344);
    idle();
    access(1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
    lit("wrap_load", 32'h1122_3344);

    // Reserved size 11 behaves as a word.
    access(1'b0, 2'b11, 1'b1, 32'h20, 32'h0);
    lit("size11_load", 32'h1234_5AAA);

    // Reset in the middle of a store keeps the old contents.
    access(1'b1, 2'b10, 1'b0, 32'h30, 32'h5555_5555);
    idle();
    abort_store(32'h30, 32'h9999_9999);
    idle();
    chk("abort_state", 32'(dbg_state), 32'd0);
    access(1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
    lit("abort_keeps", 32'h5555_5555);

    // Misaligned word load after a known load result.
    access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    access(1'b0, 2'b10, 1'b0, 32'h11, 32'h0);
`ifdef DMEM_MISALIGN_TRAP_EN
    lit("misalign_word", 32'h1234_5AAA);
    chk("misalign_err", 32'(bus.err), 32'd1);
`else
    lit("misalign_word", 32'h8000_0000);
    chk("misalign_err", 32'(bus.err), 32'd0);
`endif

    // Misaligned half store, then a word readback through the model.
    access(1'b1, 2'b01, 1'b0, 32'h31, 32'h0000_BEEF);
    access(1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
`ifdef DMEM_MISALIGN_TRAP_EN
    lit("misalign_half", 32'h5555_5555);
`else
    lit("misalign_half", 32'h5555_BEEF);
`endif
    idle();
    idle();

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
